// File: rtl/wb_master_pkg.sv
// Shared definitions for Wishbone initiators: state encoding and default bus-cycle timeout.
package wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_FINISH = 3'd5
  } wb_state_t;

  localparam int WB_TIMEOUT = 255;

endpackage

// File: rtl/wb_xfer_timer.sv
// Loadable down-counter that flags a bus cycle which has waited too long.
// A load value of zero leaves the counter idle, so it never expires.
module wb_xfer_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  // Count down while a bus cycle is outstanding; reload on each new cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Fires in the last permitted wait cycle so the abort edge lands exactly TIMEOUT cycles in.
  assign expired = en && (cnt == WIDTH'(1));

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic-cycle block copier: one single read then one single write per word,
// with a dead cycle after each access to swallow trailing acks from registered-ack slaves.
module wb_copy_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int TIMEOUT      = WB_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_adr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_adr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic                    m_we_o,
  output logic [SELECT_WIDTH-1:0] m_sel_o,
  output logic                    m_stb_o,
  output logic                    m_cyc_o,
  input  logic                    m_ack_i,
  input  logic                    m_err_i
);

  localparam int TMO_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  wb_state_t               state, state_nxt;
  logic [ADDR_WIDTH-1:0]   src, src_nxt, dst, dst_nxt;
  logic [LEN_WIDTH-1:0]    remain, remain_nxt;
  logic [DATA_WIDTH-1:0]   data, data_nxt;
  logic                    err_nxt;
  logic                    stb_nxt, we_nxt, busy_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0]   adr_nxt;
  logic [DATA_WIDTH-1:0]   dat_nxt;
  logic [SELECT_WIDTH-1:0] sel_nxt;
  logic                    tmo_load, tmo_en, tmo_expired;

  wb_xfer_timer #(
    .WIDTH(TMO_WIDTH)
  ) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (tmo_load),
    .load_val (TMO_WIDTH'(TIMEOUT)),
    .en       (tmo_en),
    .expired  (tmo_expired)
  );

  // Next-state, datapath updates and next values of the registered bus outputs.
  always_comb begin
    state_nxt  = state;
    src_nxt    = src;
    dst_nxt    = dst;
    remain_nxt = remain;
    data_nxt   = data;
    err_nxt    = err_o;

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          src_nxt    = src_adr_i;
          dst_nxt    = dst_adr_i;
          remain_nxt = len_i;
          err_nxt    = 1'b0;
          state_nxt  = (len_i == '0) ? ST_FINISH : ST_RD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      // Error beats ack; ack beats a coincident timeout.
      ST_RD: begin
        if (m_err_i) begin
          err_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end else if (m_ack_i) begin
          data_nxt  = m_dat_i;
          src_nxt   = src + ADDR_WIDTH'(SELECT_WIDTH);
          state_nxt = ST_RD_GAP;
        end else if (tmo_expired) begin
          err_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_RD;
        end
      end
      ST_RD_GAP: state_nxt = ST_WR;
      ST_WR: begin
        if (m_err_i) begin
          err_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end else if (m_ack_i) begin
          dst_nxt   = dst + ADDR_WIDTH'(SELECT_WIDTH);
          state_nxt = ST_WR_GAP;
        end else if (tmo_expired) begin
          err_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_WR;
        end
      end
      ST_WR_GAP: begin
        remain_nxt = remain - LEN_WIDTH'(1);
        state_nxt  = (remain == LEN_WIDTH'(1)) ? ST_FINISH : ST_RD;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    tmo_en   = (state == ST_RD) || (state == ST_WR);
    tmo_load = ((state_nxt == ST_RD) || (state_nxt == ST_WR)) && (state_nxt != state);

    stb_nxt  = (state_nxt == ST_RD) || (state_nxt == ST_WR);
    we_nxt   = (state_nxt == ST_WR);
    sel_nxt  = stb_nxt ? {SELECT_WIDTH{1'b1}} : {SELECT_WIDTH{1'b0}};
    dat_nxt  = (state_nxt == ST_WR) ? data_nxt : {DATA_WIDTH{1'b0}};
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_FINISH);

    case (state_nxt)
      ST_RD:   adr_nxt = src_nxt;
      ST_WR:   adr_nxt = dst_nxt;
      default: adr_nxt = {ADDR_WIDTH{1'b0}};
    endcase
  end

  // State, datapath and bus outputs; reset clears everything immediately, dropping cyc/stb mid-transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      src     <= '0;
      dst     <= '0;
      remain  <= '0;
      data    <= '0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_stb_o <= 1'b0;
      m_cyc_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      src     <= src_nxt;
      dst     <= dst_nxt;
      remain  <= remain_nxt;
      data    <= data_nxt;
      err_o   <= err_nxt;
      busy_o  <= busy_nxt;
      done_o  <= done_nxt;
      m_adr_o <= adr_nxt;
      m_dat_o <= dat_nxt;
      m_we_o  <= we_nxt;
      m_sel_o <= sel_nxt;
      m_stb_o <= stb_nxt;
      m_cyc_o <= stb_nxt;
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master against a registered-ack RAM slave model that also
// produces a trailing ack, with injectable error and no-ack behaviour.
module tb_wb_copy_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] src_adr_i, dst_adr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] m_adr_o;
  logic [DW-1:0] m_dat_o;
  logic [DW-1:0] m_dat_i = '0;
  logic          m_we_o;
  logic [SW-1:0] m_sel_o;
  logic          m_stb_o, m_cyc_o;
  logic          m_ack_i = 1'b0;
  logic          m_err_i = 1'b0;

  always #5 clk = ~clk;

  wb_copy_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .LEN_WIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  // Slave model state and controls
  logic [31:0] mem [0:255];
  logic        stb_q = 1'b0;
  int          acc_cnt = 0, stb_hi = 0, wr_seen = 0;
  logic        sel_bad = 1'b0;
  logic [31:0] log_adr [0:63];
  logic        log_we  [0:63];
  logic        clr = 1'b0, no_ack = 1'b0, pl_en = 1'b0;
  int          err_wr = -1;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_val = 32'd0;

  // Registered-ack RAM: ack follows stb by one edge and repeats once after stb drops.
  always @(posedge clk) begin
    stb_q <= m_stb_o;
    if (pl_en) mem[pl_idx] <= pl_val;
    if (clr) begin
      acc_cnt <= 0; stb_hi <= 0; wr_seen <= 0; sel_bad <= 1'b0;
    end else begin
      if (m_stb_o) stb_hi <= stb_hi + 1;
      if ((m_stb_o ? (m_sel_o != 4'hF) : (m_sel_o != 4'h0)) || (m_cyc_o != m_stb_o)) sel_bad <= 1'b1;
      if (m_stb_o && !stb_q) begin
        if (acc_cnt < 64) begin
          log_adr[acc_cnt[5:0]] <= m_adr_o;
          log_we[acc_cnt[5:0]]  <= m_we_o;
        end
        acc_cnt <= acc_cnt + 1;
        if (m_we_o) wr_seen <= wr_seen + 1;
      end
    end
    if (no_ack || !m_stb_o) begin
      m_ack_i <= 1'b0; m_err_i <= 1'b0;
    end else if (m_we_o && (wr_seen == err_wr)) begin
      m_ack_i <= 1'b0; m_err_i <= 1'b1;
    end else begin
      m_ack_i <= 1'b1; m_err_i <= 1'b0;
    end
    if (m_stb_o && m_we_o && !stb_q && !no_ack && (wr_seen != err_wr)) mem[m_adr_o[9:2]] <= m_dat_o;
    m_dat_i <= mem[m_adr_o[9:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Start a transfer; cyc counts edges from the accepting edge (1) to the edge after which done_o is seen.
  task automatic run_xfer(input logic [15:0] len, input logic [31:0] src, input logic [31:0] dst,
                          input int poke_at, output int cyc, output int busy_cnt);
    bit seen;
    @(negedge clk);
    start_i = 1'b1; len_i = len; src_adr_i = src; dst_adr_i = dst;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
      if (busy_o) busy_cnt++;
      if (done_o) seen = 1'b1;
      if (cyc == poke_at) begin
        start_i = 1'b1; len_i = 16'd5; src_adr_i = 32'h0000_0600; dst_adr_i = 32'h0000_0700;
      end
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done_o}, 64'd0);
    chk("busy_after_done", {63'd0, busy_o}, 64'd0);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] base;
    int          exp_cyc;
    int          exp_acc;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc, bcnt;
    logic [7:0] sidx, didx;
    logic [31:0] wv;

    vecs[0] = '{16'd1, 32'h0000_0000, 32'h0000_0040, 32'hDEAD_BEEF, 7,  2};
    vecs[1] = '{16'd4, 32'h0000_0100, 32'h0000_0200, 32'h1111_1111, 25, 8};
    vecs[2] = '{16'd0, 32'h0000_0020, 32'h0000_0030, 32'h0000_0000, 1,  0};
    vecs[3] = '{16'd2, 32'h0000_0010, 32'h0000_0080, 32'h0102_0304, 13, 4};

    rst_i = 1'b1; start_i = 1'b0; len_i = '0; src_adr_i = '0; dst_adr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err",  {63'd0, err_o},  64'd0);
    chk("rst_stb",  {62'd0, m_stb_o, m_cyc_o}, 64'd0);
    chk("rst_adr",  {32'd0, m_adr_o}, 64'd0);
    chk("rst_sel",  {60'd0, m_sel_o}, 64'd0);
    @(negedge clk); rst_i = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        sidx = vecs[v].src[9:2] + 8'(k);
        preload(sidx, vecs[v].base + 32'(k) * 32'h1111_1111);
      end
      clear_log();
      run_xfer(vecs[v].len, vecs[v].src, vecs[v].dst, -1, cyc, bcnt);
      chk("vec_done_latency", 64'(cyc), 64'(vecs[v].exp_cyc));
      chk("vec_busy_cycles",  64'(bcnt), 64'(vecs[v].exp_cyc));
      chk("vec_accesses",     64'(acc_cnt), 64'(vecs[v].exp_acc));
      chk("vec_stb_cycles",   64'(stb_hi), 64'(2 * vecs[v].exp_acc));
      chk("vec_sel_cyc",      {63'd0, sel_bad}, 64'd0);
      chk("vec_err",          {63'd0, err_o}, 64'd0);
      for (int k = 0; k < int'(vecs[v].len); k++) begin
        didx = vecs[v].dst[9:2] + 8'(k);
        wv = vecs[v].base + 32'(k) * 32'h1111_1111;
        chk("vec_copied_word", {32'd0, mem[didx]}, {32'd0, wv});
        chk("vec_rd_adr", {32'd0, log_adr[2*k]},   {32'd0, vecs[v].src + 32'(4 * k)});
        chk("vec_rd_we",  {63'd0, log_we[2*k]},    64'd0);
        chk("vec_wr_adr", {32'd0, log_adr[2*k+1]}, {32'd0, vecs[v].dst + 32'(4 * k)});
        chk("vec_wr_we",  {63'd0, log_we[2*k+1]},  64'd1);
      end
    end

    // Error on the second write of a three-word copy.
    preload(8'hC0, 32'hA000_0000);
    preload(8'hC1, 32'hA000_0001);
    preload(8'hC2, 32'hA000_0002);
    preload(8'hE1, 32'hCAFE_0001);
    clear_log();
    @(negedge clk); err_wr = 1;
    run_xfer(16'd3, 32'h0000_0300, 32'h0000_0380, -1, cyc, bcnt);
    chk("err_latency", 64'(cyc), 64'd12);
    chk("err_accesses", 64'(acc_cnt), 64'd4);
    chk("err_flag", {63'd0, err_o}, 64'd1);
    chk("err_word0", {32'd0, mem[8'hE0]}, {32'd0, 32'hA000_0000});
    chk("err_word1_untouched", {32'd0, mem[8'hE1]}, {32'd0, 32'hCAFE_0001});
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", {63'd0, err_o}, 64'd1);
    @(negedge clk); err_wr = -1;
    run_xfer(16'd0, 32'h0, 32'h0, -1, cyc, bcnt);
    chk("err_cleared_on_start", {63'd0, err_o}, 64'd0);

    // Slave never answers: timeout after TO cycles in RD, start while busy ignored.
    clear_log();
    @(negedge clk); no_ack = 1'b1;
    run_xfer(16'd1, 32'h0000_0040, 32'h0000_0440, 3, cyc, bcnt);
    chk("tmo_latency", 64'(cyc), 64'd9);
    chk("tmo_stb_cycles", 64'(stb_hi), 64'd8);
    chk("tmo_err", {63'd0, err_o}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo_start_ignored_busy", {63'd0, busy_o}, 64'd0);
    chk("tmo_start_ignored_acc", 64'(acc_cnt), 64'd1);
    @(negedge clk); no_ack = 1'b0;

    // Source address wrap at the top of the address space.
    preload(8'hFF, 32'hA5A5_A5A5);
    preload(8'h00, 32'h5A5A_5A5A);
    clear_log();
    run_xfer(16'd2, 32'hFFFF_FFFC, 32'h0000_0500, -1, cyc, bcnt);
    chk("wrap_rd0_adr", {32'd0, log_adr[0]}, {32'd0, 32'hFFFF_FFFC});
    chk("wrap_rd1_adr", {32'd0, log_adr[2]}, 64'd0);
    chk("wrap_word0", {32'd0, mem[8'h40]}, {32'd0, 32'hA5A5_A5A5});
    chk("wrap_word1", {32'd0, mem[8'h41]}, {32'd0, 32'h5A5A_5A5A});

    // Asynchronous reset in the middle of a write cycle.
    @(negedge clk);
    start_i = 1'b1; len_i = 16'd1; src_adr_i = 32'h0; dst_adr_i = 32'h0000_0580;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 20 && !(m_stb_o && m_we_o); i++) begin
      @(posedge clk); #1;
    end
    chk("rstwr_reached_wr", {63'd0, m_stb_o && m_we_o}, 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rstwr_cyc", {63'd0, m_cyc_o}, 64'd0);
    chk("rstwr_stb", {63'd0, m_stb_o}, 64'd0);
    chk("rstwr_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk); rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstwr_idle_after", {61'd0, busy_o, done_o, m_stb_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
- Wishbone classic-cycle initiator that copies a block of words from a source address to a destination address.
- Each word is one single read cycle followed by one single write cycle.
- Drives the slave ports of the dual-port RAM and other registered-ack slaves on the fabric.
- Controlled by a start/busy/done interface from the CPU-side register block.

Parameters:
- ADDR_WIDTH, 32, Wishbone byte-address width.
- DATA_WIDTH, 32, data bus width (8/16/32/64).
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- LEN_WIDTH, 16, width of the word-count input.
- TIMEOUT, 255, max cycles waiting for ack/err per bus cycle; 0 disables the timeout.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE.
- src_adr_i  in  ADDR_WIDTH  source byte address; latched on start.
- dst_adr_i  in  ADDR_WIDTH  destination byte address; latched on start.
- len_i  in  LEN_WIDTH  number of words; latched on start.
- busy_o  out  1  high from the cycle after an accepted start until FINISH is left.
- done_o  out  1  one-cycle completion pulse (success or abort).
- err_o  out  1  sticky abort flag; cleared on the next accepted start.
- m_adr_o  out  ADDR_WIDTH  WB address.
- m_dat_o  out  DATA_WIDTH  WB write data.
- m_dat_i  in  DATA_WIDTH  WB read data.
- m_we_o  out  1  WB write enable.
- m_sel_o  out  SELECT_WIDTH  WB byte select; always all ones while stb is high, 0 otherwise.
- m_stb_o  out  1  WB strobe.
- m_cyc_o  out  1  WB cycle; equals m_stb_o.
- m_ack_i  in  1  WB acknowledge.
- m_err_i  in  1  WB error.

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, counters/latches 0. Asserting mid-transfer drops cyc/stb at once; no partial-word recovery.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FINISH.
- IDLE: start_i=1 latches src/dst/len, clears err_o, sets busy_o. If len=0, go to FINISH; else go to RD.
- RD: cyc=stb=1, we=0, adr=src. On m_ack_i, capture m_dat_i into the data register and go to RD_GAP.
- WR: cyc=stb=1, we=1, adr=dst, dat=data register. On m_ack_i, go to WR_GAP.
- RD_GAP / WR_GAP: exactly one cycle with cyc=stb=0; m_ack_i and m_err_i are ignored. This absorbs the trailing ack from a registered-ack slave that still saw stb high on the ack edge.
- After WR_GAP: decrement the remaining count. If 0, go to FINISH; else go to RD.
- Address advance: src and dst each advance by SELECT_WIDTH after their own ack, modulo 2^ADDR_WIDTH (wraps silently). Low log2(SELECT_WIDTH) bits are passed through unchanged.
- Error: m_err_i in RD or WR (ack and err both high counts as err) aborts. stb/cyc drop next edge, err_o=1, go to FINISH; no further bus cycles.
- Timeout: the counter resets on entry to RD/WR. If it reaches TIMEOUT with no ack/err, abort exactly as for an error.
- FINISH: one cycle; done_o=1, busy_o=1. Next state is IDLE with busy_o=0.
- start_i is ignored when not in IDLE.
- Timing against a one-cycle registered-ack slave: RD 2 cycles + gap 1 + WR 2 + gap 1 = 6 cycles/word. Total from the start edge to the done_o pulse is 6·N+1 cycles.

Decomposition:
- Shared package wb_master_pkg holds the state encoding constants and the WB_TIMEOUT default, so future initiators reuse them.
- One natural sub-module, wb_xfer_timer: loadable down-counter with a timeout pulse, reusable by other masters.

Test Plan:
- len=1, src=0x00, dst=0x40, RAM[0]=0xDEADBEEF, RAM slave acking 1 cycle after stb -> RAM[0x10 word]=0xDEADBEEF. done_o pulses exactly 7 cycles after the start edge; sel=4'hF on both cycles; no stb during the gap cycles.
- len=4, src=0x100, dst=0x200, pattern 0x11111111..0x44444444 -> all four copied in order; exactly 8 stb-high bus cycles, alternating we=0/1; err_o=0.
- len=0 -> done_o pulses the cycle after FINISH entry with no cyc/stb activity; busy_o high for exactly 1 cycle.
- len=3, slave asserts m_err_i on the 2nd write -> word 0 copied, word 1 not written, no 3rd read. err_o=1 stays sticky until the next start, then clears.
- Slave never acks, TIMEOUT=8 -> stb drops after 8 cycles in RD, err_o=1, done_o pulse. start_i pulsed while busy has no effect.
- src=0xFFFFFFFC, len=2 -> second read address wraps to 0x00000000. Separately, rst_i asserted during WR -> m_cyc_o/m_stb_o/busy_o go 0 combinationally before the next edge.
